pc_stage_vec: RTL and testbench
===============================

# pc_stage_vec

Parametrised program-counter stage with an N-channel interrupt front end. It owns the fetch PC and selects each next PC from CPU start load, mret, sticky ecall/ebreak exceptions, prioritised interrupts, branch/jump, or sequential increment. It supports direct and vectored trap modes. It sits between the EX stage (jump/trap requests) and the CSR block, which consumes the registered trap report.

## Interface
Parameters:
- NUM_IRQ, 4: interrupt channels, 1..16.
- VECTORED, 1: 1 honours mtvec mode bit for interrupts; 0 forces direct mode.
- RESET_ADR, 30'h0: PC value after reset (word address).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_start  in  1  request to load cpu_start_adr.
- cpu_start_adr  in  30  start word address [31:2].
- cpu_stat_pc  in  1  PC advance strobe; all PC updates are qualified by it.
- csr_rmie  in  1  global interrupt enable.
- irq_in  in  NUM_IRQ  level interrupt lines.
- irq_en  in  NUM_IRQ  per-channel enable mask.
- jmp_condition_ex  in  1  branch/jump taken.
- jmp_adr_ex  in  30  jump target.
- cmd_ecall_ex, cmd_ebreak_ex, cmd_mret_ex  in  1 each  EX-stage commands.
- pc_ex  in  30  address of the instruction in EX.
- csr_mtvec_ex  in  32  mtvec; [1:0] is the mode, where 01 means vectored.
- csr_mepc_ex  in  30  mepc return address.
- pc  out  30  current fetch PC.
- irq_pending  out  NUM_IRQ  pending latches.
- trap_take  out  1  registered one-cycle trap report pulse.
- trap_cause  out  5  cause code: 11 ecall, 3 ebreak, 16+i interrupt i.
- mepc_save  out  30  return address to write into mepc.

## Operation
- Start latch:
  - Set by cpu_start; cleared on cpu_stat_pc.
  - cpu_start also clears the ecall/ebreak keepers.
- Exception keepers (ecall, ebreak):
  - Set by cmd_*_ex; cleared on cpu_stat_pc.
  - Exceptions are taken regardless of csr_rmie.
- Interrupt edge detection:
  - irq_d registers irq_in each cycle.
  - Pending bit i is set when irq_in[i] & ~irq_d[i] & irq_en[i].
  - Pending bit i is cleared when interrupt i is taken.
  - If set and clear hit the same bit in the same cycle, set wins.
- Interrupt select:
  - irq_req = irq_pending & irq_en.
  - The lowest set index wins (fixed priority).
  - An interrupt is eligible only when csr_rmie=1.
- Next-PC priority on cpu_stat_pc=1, highest first:
  1. Start latch: pc <= cpu_start_adr.
  2. cmd_mret_ex: pc <= csr_mepc_ex.
  3. ecall keeper: trap, pc <= mtvec base.
  4. ebreak keeper: trap, pc <= mtvec base.
  5. Eligible interrupt i: trap; pc <= base + 16 + i if VECTORED & mode==01, else base.
  6. jmp_condition_ex: pc <= jmp_adr_ex.
  7. Otherwise pc <= pc + 1 (30-bit, wraps 3FFFFFFF -> 0).
- mtvec base is csr_mtvec_ex[31:2]. Vector offset arithmetic is 30-bit modulo.
- mepc_save:
  - Exception: pc_ex.
  - Interrupt: jmp_adr_ex if jmp_condition_ex, else pc + 1 (the instruction that did not retire).
- A lower-priority trap request is not dropped:
  - Keepers hold until the next cpu_stat_pc.
  - Pending bits hold until their interrupt is taken.
- With cpu_stat_pc=0, pc holds and no trap is taken.

## Timing
- Reset values:
  - pc = RESET_ADR.
  - irq_pending, irq_d, keepers, start latch, trap_take, trap_cause, mepc_save all 0.
- pc updates on the clk edge where cpu_stat_pc=1.
- trap_take pulses for exactly one cycle after the edge that loaded the trap PC. trap_cause and mepc_save are valid in that cycle and hold until the next trap.
- Interrupt latency: irq_in rising at edge k gives pending=1 after edge k+1. The trap is taken at the first cpu_stat_pc edge after that.
- A level held high does not re-pend. It must fall and rise again.
- mret and a pending interrupt in the same strobe: mret wins; the interrupt is taken on the next strobe.
- Reset asserted mid-operation clears all state immediately, including any trap in flight.

## Test plan
- Reset, RESET_ADR=0x100, cpu_start with adr 0x40, then 3 strobes -> pc = 0x40, 0x41, 0x42; trap_take never asserted.
- mtvec=0x1000_0001 (vectored), irq_in[2] rises at pc=0x50 with no jump -> trap at next strobe: pc=0x0400_0012, trap_cause=18, mepc_save=0x51, irq_pending[2] cleared.
- irq_in[1] and irq_in[3] rise together, csr_rmie=1 -> channel 1 taken first (cause 17); channel 3 taken on the following strobe (cause 19).
- cmd_ecall_ex with pc_ex=0x20, mtvec=0x1000_0001, irq_in[0] pending -> ecall wins: pc=0x0400_0000, cause=11, mepc_save=0x20; irq 0 taken on the next strobe.
- csr_rmie=0 with irq_in[0] rising -> pending=1, no trap. Raise csr_rmie -> trap on the next strobe.
- pc=0x3FFFFFFF, strobe -> pc=0. Assert rst_n low mid-trap -> pc=RESET_ADR and all pending bits 0 immediately.

Source files
------------

// File: rtl/pc_stage_vec.sv
// Fetch-PC stage with N-channel interrupt front end; pc and trap report update one clock after a cpu_stat_pc strobe.
// No backpressure: without cpu_stat_pc the pc and traps wait, while keepers and pending bits hold their requests.
module pc_stage_vec #(
  parameter int          NUM_IRQ   = 4,
  parameter bit          VECTORED  = 1'b1,
  parameter logic [29:0] RESET_ADR = 30'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_start,
  input  logic [29:0]        cpu_start_adr,
  input  logic               cpu_stat_pc,
  input  logic               csr_rmie,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               jmp_condition_ex,
  input  logic [29:0]        jmp_adr_ex,
  input  logic               cmd_ecall_ex,
  input  logic               cmd_ebreak_ex,
  input  logic               cmd_mret_ex,
  input  logic [29:0]        pc_ex,
  input  logic [31:0]        csr_mtvec_ex,
  input  logic [29:0]        csr_mepc_ex,
  output logic [29:0]        pc,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               trap_take,
  output logic [4:0]         trap_cause,
  output logic [29:0]        mepc_save
);

  logic [29:0]        pc_q, pc_d;
  logic               start_q, start_d;
  logic               ecall_q, ecall_d;
  logic               ebreak_q, ebreak_d;
  logic [NUM_IRQ-1:0] irq_d_q, irq_d_d;
  logic [NUM_IRQ-1:0] irq_pending_q, irq_pending_d;
  logic               trap_take_q, trap_take_d;
  logic [4:0]         trap_cause_q, trap_cause_d;
  logic [29:0]        mepc_save_q, mepc_save_d;

  logic [29:0]        mtvec_base;
  logic [29:0]        pc_inc;
  logic               vec_mode;
  logic [NUM_IRQ-1:0] irq_req;
  logic [NUM_IRQ-1:0] irq_rise;
  logic [NUM_IRQ-1:0] irq_onehot;
  logic [4:0]         irq_sel;
  logic               irq_found;
  logic               irq_take;
  logic               ecall_eff;
  logic               ebreak_eff;

  always_comb begin
    mtvec_base = csr_mtvec_ex[31:2];
    pc_inc     = pc_q + 30'd1;
    vec_mode   = VECTORED && (csr_mtvec_ex[1:0] == 2'b01);
    irq_req    = irq_pending_q & irq_en;
    irq_rise   = irq_in & ~irq_d_q & irq_en;

    // Fixed priority: lowest requesting channel index wins.
    irq_onehot = '0;
    irq_sel    = 5'd0;
    irq_found  = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (irq_req[i] && !irq_found) begin
        irq_found     = 1'b1;
        irq_sel       = 5'(i);
        irq_onehot[i] = 1'b1;
      end
    end
    irq_take = csr_rmie & irq_found;

    // A command arriving on the strobe cycle itself is honoured without waiting for its keeper.
    ecall_eff  = ecall_q | cmd_ecall_ex;
    ebreak_eff = ebreak_q | cmd_ebreak_ex;

    pc_d         = pc_q;
    trap_take_d  = 1'b0;
    trap_cause_d = trap_cause_q;
    mepc_save_d  = mepc_save_q;
    irq_pending_d = irq_pending_q;

    if (cpu_stat_pc) begin
      if (start_q) begin
        pc_d = cpu_start_adr;
      end else if (cmd_mret_ex) begin
        pc_d = csr_mepc_ex;
      end else if (ecall_eff) begin
        pc_d         = mtvec_base;
        trap_take_d  = 1'b1;
        trap_cause_d = 5'd11;
        mepc_save_d  = pc_ex;
      end else if (ebreak_eff) begin
        pc_d         = mtvec_base;
        trap_take_d  = 1'b1;
        trap_cause_d = 5'd3;
        mepc_save_d  = pc_ex;
      end else if (irq_take) begin
        pc_d          = vec_mode ? (mtvec_base + 30'd16 + 30'(irq_sel)) : mtvec_base;
        trap_take_d   = 1'b1;
        trap_cause_d  = 5'd16 + irq_sel;
        mepc_save_d   = jmp_condition_ex ? jmp_adr_ex : pc_inc;
        irq_pending_d = irq_pending_q & ~irq_onehot;
      end else if (jmp_condition_ex) begin
        pc_d = jmp_adr_ex;
      end else begin
        pc_d = pc_inc;
      end
    end

    // A new edge on the channel being taken re-pends it.
    irq_pending_d = irq_pending_d | irq_rise;
    irq_d_d       = irq_in;

    start_d  = cpu_start | (start_q & ~cpu_stat_pc);
    ecall_d  = ~cpu_start & ~cpu_stat_pc & ecall_eff;
    ebreak_d = ~cpu_start & ~cpu_stat_pc & ebreak_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_ADR;
      start_q       <= 1'b0;
      ecall_q       <= 1'b0;
      ebreak_q      <= 1'b0;
      irq_d_q       <= '0;
      irq_pending_q <= '0;
      trap_take_q   <= 1'b0;
      trap_cause_q  <= 5'd0;
      mepc_save_q   <= 30'd0;
    end else begin
      pc_q          <= pc_d;
      start_q       <= start_d;
      ecall_q       <= ecall_d;
      ebreak_q      <= ebreak_d;
      irq_d_q       <= irq_d_d;
      irq_pending_q <= irq_pending_d;
      trap_take_q   <= trap_take_d;
      trap_cause_q  <= trap_cause_d;
      mepc_save_q   <= mepc_save_d;
    end
  end

  assign pc          = pc_q;
  assign irq_pending = irq_pending_q;
  assign trap_take   = trap_take_q;
  assign trap_cause  = trap_cause_q;
  assign mepc_save   = mepc_save_q;

endmodule

// File: tb/tb_pc_stage_vec.sv
// Directed bench for pc_stage_vec: a table of sequential/jump/start vectors, then hand-written trap sequences.
module tb_pc_stage_vec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_start;
  logic [29:0] cpu_start_adr;
  logic        cpu_stat_pc;
  logic        csr_rmie;
  logic [3:0]  irq_in;
  logic [3:0]  irq_en;
  logic        jmp_condition_ex;
  logic [29:0] jmp_adr_ex;
  logic        cmd_ecall_ex;
  logic        cmd_ebreak_ex;
  logic        cmd_mret_ex;
  logic [29:0] pc_ex;
  logic [31:0] csr_mtvec_ex;
  logic [29:0] csr_mepc_ex;
  logic [29:0] pc;
  logic [3:0]  irq_pending;
  logic        trap_take;
  logic [4:0]  trap_cause;
  logic [29:0] mepc_save;

  int n_pass  = 0;
  int n_total = 0;

  pc_stage_vec #(.NUM_IRQ(4), .VECTORED(1'b1), .RESET_ADR(30'h100)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_start(cpu_start), .cpu_start_adr(cpu_start_adr),
    .cpu_stat_pc(cpu_stat_pc), .csr_rmie(csr_rmie), .irq_in(irq_in), .irq_en(irq_en),
    .jmp_condition_ex(jmp_condition_ex), .jmp_adr_ex(jmp_adr_ex),
    .cmd_ecall_ex(cmd_ecall_ex), .cmd_ebreak_ex(cmd_ebreak_ex), .cmd_mret_ex(cmd_mret_ex),
    .pc_ex(pc_ex), .csr_mtvec_ex(csr_mtvec_ex), .csr_mepc_ex(csr_mepc_ex),
    .pc(pc), .irq_pending(irq_pending), .trap_take(trap_take),
    .trap_cause(trap_cause), .mepc_save(mepc_save)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [29:0] sadr;
    logic        stat;
    logic        jmp;
    logic [29:0] jadr;
    logic [29:0] exp_pc;
  } vec_t;

  localparam int NTBL = 14;
  vec_t tbl [NTBL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick(input logic stat);
    cpu_stat_pc = stat;
    @(posedge clk);
    #1;
    cpu_stat_pc = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 30'h3FFFFFFF, 1'b0, 1'b0, 30'h0,  30'h100};
    tbl[1]  = '{1'b0, 30'h3FFFFFFF, 1'b1, 1'b0, 30'h0,  30'h3FFFFFFF};
    tbl[2]  = '{1'b0, 30'h3FFFFFFF, 1'b1, 1'b0, 30'h0,  30'h0};
    tbl[3]  = '{1'b0, 30'h3FFFFFFF, 1'b1, 1'b0, 30'h0,  30'h1};
    tbl[4]  = '{1'b1, 30'h40,       1'b0, 1'b0, 30'h0,  30'h1};
    tbl[5]  = '{1'b0, 30'h40,       1'b1, 1'b0, 30'h0,  30'h40};
    tbl[6]  = '{1'b0, 30'h40,       1'b1, 1'b0, 30'h0,  30'h41};
    tbl[7]  = '{1'b0, 30'h40,       1'b1, 1'b0, 30'h0,  30'h42};
    tbl[8]  = '{1'b0, 30'h40,       1'b0, 1'b0, 30'h0,  30'h42};
    tbl[9]  = '{1'b0, 30'h40,       1'b1, 1'b1, 30'h80, 30'h80};
    tbl[10] = '{1'b0, 30'h40,       1'b0, 1'b1, 30'h90, 30'h80};
    tbl[11] = '{1'b0, 30'h40,       1'b1, 1'b0, 30'h0,  30'h81};
    tbl[12] = '{1'b1, 30'h50,       1'b0, 1'b0, 30'h0,  30'h81};
    tbl[13] = '{1'b0, 30'h50,       1'b1, 1'b0, 30'h0,  30'h50};

    rst_n = 1'b0;
    cpu_start = 1'b0; cpu_start_adr = '0; cpu_stat_pc = 1'b0; csr_rmie = 1'b0;
    irq_in = '0; irq_en = '0; jmp_condition_ex = 1'b0; jmp_adr_ex = '0;
    cmd_ecall_ex = 1'b0; cmd_ebreak_ex = 1'b0; cmd_mret_ex = 1'b0;
    pc_ex = '0; csr_mtvec_ex = '0; csr_mepc_ex = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", 32'(pc), 32'h100);
    chk("reset_pending", 32'(irq_pending), 32'h0);
    chk("reset_trap_take", 32'(trap_take), 32'h0);
    chk("reset_cause", 32'(trap_cause), 32'h0);
    chk("reset_mepc_save", 32'(mepc_save), 32'h0);
    rst_n = 1'b1;

    for (int r = 0; r < NTBL; r++) begin
      cpu_start        = tbl[r].start;
      cpu_start_adr    = tbl[r].sadr;
      jmp_condition_ex = tbl[r].jmp;
      jmp_adr_ex       = tbl[r].jadr;
      tick(tbl[r].stat);
      chk($sformatf("tbl%0d_pc", r), 32'(pc), 32'(tbl[r].exp_pc));
      chk($sformatf("tbl%0d_trap", r), 32'(trap_take), 32'h0);
    end
    cpu_start = 1'b0; jmp_condition_ex = 1'b0;

    // Vectored interrupt on channel 2 from pc=0x50
    csr_mtvec_ex = 32'h1000_0001; csr_rmie = 1'b1; irq_en = 4'hF;
    irq_in = 4'b0100;
    tick(1'b0);
    chk("irq2_pending", 32'(irq_pending), 32'h4);
    chk("irq2_no_trap_yet", 32'(trap_take), 32'h0);
    tick(1'b1);
    chk("irq2_pc", 32'(pc), 32'h0400_0012);
    chk("irq2_take", 32'(trap_take), 32'h1);
    chk("irq2_cause", 32'(trap_cause), 32'd18);
    chk("irq2_mepc", 32'(mepc_save), 32'h51);
    chk("irq2_cleared", 32'(irq_pending), 32'h0);
    tick(1'b0);
    chk("irq2_pulse_end", 32'(trap_take), 32'h0);
    chk("irq2_cause_hold", 32'(trap_cause), 32'd18);
    chk("irq2_level_no_repend", 32'(irq_pending), 32'h0);
    irq_in = 4'b0000;
    tick(1'b0);

    // Channels 1 and 3 together; first taken while a jump is in EX
    irq_in = 4'b1010;
    tick(1'b0);
    chk("irq13_pending", 32'(irq_pending), 32'hA);
    jmp_condition_ex = 1'b1; jmp_adr_ex = 30'h200;
    tick(1'b1);
    jmp_condition_ex = 1'b0;
    chk("irq1_pc", 32'(pc), 32'h0400_0011);
    chk("irq1_cause", 32'(trap_cause), 32'd17);
    chk("irq1_mepc_jmp", 32'(mepc_save), 32'h200);
    chk("irq1_left3", 32'(irq_pending), 32'h8);
    tick(1'b1);
    chk("irq3_pc", 32'(pc), 32'h0400_0013);
    chk("irq3_cause", 32'(trap_cause), 32'd19);
    chk("irq3_take", 32'(trap_take), 32'h1);
    chk("irq3_mepc", 32'(mepc_save), 32'h0400_0012);
    irq_in = 4'b0000;
    tick(1'b0);

    // ecall beats a pending irq 0; keeper holds across a non-strobe cycle
    irq_in = 4'b0001;
    tick(1'b0);
    cmd_ecall_ex = 1'b1; pc_ex = 30'h20;
    tick(1'b0);
    cmd_ecall_ex = 1'b0;
    chk("ecall_wait_pc", 32'(pc), 32'h0400_0013);
    chk("ecall_wait_trap", 32'(trap_take), 32'h0);
    tick(1'b1);
    chk("ecall_pc", 32'(pc), 32'h0400_0000);
    chk("ecall_cause", 32'(trap_cause), 32'd11);
    chk("ecall_mepc", 32'(mepc_save), 32'h20);
    chk("ecall_irq_kept", 32'(irq_pending), 32'h1);
    tick(1'b1);
    chk("irq0_after_ecall_pc", 32'(pc), 32'h0400_0010);
    chk("irq0_after_ecall_cause", 32'(trap_cause), 32'd16);
    chk("irq0_after_ecall_mepc", 32'(mepc_save), 32'h0400_0001);
    irq_in = 4'b0000;

    // ebreak
    cmd_ebreak_ex = 1'b1; pc_ex = 30'h30;
    tick(1'b0);
    cmd_ebreak_ex = 1'b0;
    tick(1'b1);
    chk("ebreak_pc", 32'(pc), 32'h0400_0000);
    chk("ebreak_cause", 32'(trap_cause), 32'd3);
    chk("ebreak_mepc", 32'(mepc_save), 32'h30);

    // mret beats a pending interrupt
    irq_in = 4'b0001;
    tick(1'b0);
    cmd_mret_ex = 1'b1; csr_mepc_ex = 30'h77;
    tick(1'b1);
    cmd_mret_ex = 1'b0;
    chk("mret_pc", 32'(pc), 32'h77);
    chk("mret_no_trap", 32'(trap_take), 32'h0);
    chk("mret_irq_kept", 32'(irq_pending), 32'h1);
    tick(1'b1);
    chk("irq0_after_mret_cause", 32'(trap_cause), 32'd16);
    chk("irq0_after_mret_mepc", 32'(mepc_save), 32'h78);
    irq_in = 4'b0000;
    tick(1'b0);

    // Global enable off: pend without trapping, then release
    csr_rmie = 1'b0;
    irq_in = 4'b0010;
    tick(1'b0);
    tick(1'b1);
    chk("rmie0_no_trap", 32'(trap_take), 32'h0);
    chk("rmie0_pending", 32'(irq_pending), 32'h2);
    chk("rmie0_pc_inc", 32'(pc), 32'h0400_0011);
    csr_rmie = 1'b1;
    tick(1'b1);
    chk("rmie1_take", 32'(trap_take), 32'h1);
    chk("rmie1_cause", 32'(trap_cause), 32'd17);
    chk("rmie1_mepc", 32'(mepc_save), 32'h0400_0012);
    irq_in = 4'b0000;
    tick(1'b0);

    // Direct mode and a masked channel
    csr_mtvec_ex = 32'h1000_0000;
    irq_en = 4'b1110;
    irq_in = 4'b1001;
    tick(1'b0);
    chk("masked_ch0", 32'(irq_pending), 32'h8);
    tick(1'b1);
    chk("direct_pc", 32'(pc), 32'h0400_0000);
    chk("direct_cause", 32'(trap_cause), 32'd19);
    irq_in = 4'b0000; irq_en = 4'hF;
    tick(1'b0);

    // Reset in the middle of a trap
    csr_mtvec_ex = 32'h1000_0001;
    irq_in = 4'b0100;
    tick(1'b0);
    irq_in = 4'b0110;
    tick(1'b1);
    chk("pre_reset_take", 32'(trap_take), 32'h1);
    chk("pre_reset_pending", 32'(irq_pending), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_pc", 32'(pc), 32'h100);
    chk("midreset_pending", 32'(irq_pending), 32'h0);
    chk("midreset_take", 32'(trap_take), 32'h0);
    chk("midreset_cause", 32'(trap_cause), 32'h0);
    irq_in = 4'b0000;
    #2 rst_n = 1'b1;
    tick(1'b0);
    chk("post_reset_pc", 32'(pc), 32'h100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
